// File: rtl/mem_arbiter.sv
// Shares one 32-bit memory port between the LSU and the IFU. Reads are aborted
// if they run past a timeout. Define MEM_ARB_RR_EN for round-robin; the default is fixed LSU priority.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_lsu_addr,
  input  logic        io_lsu_w_req,
  input  logic [31:0] io_lsu_w_data,
  input  logic        io_lsu_r_req,
  output logic [31:0] io_lsu_r_data,
  output logic        io_lsu_done,
  output logic        io_lsu_err,
  output logic        io_lsu_busy,
  input  logic [31:0] io_ifu_addr,
  input  logic        io_ifu_r_req,
  output logic [31:0] io_ifu_r_data,
  output logic        io_ifu_done,
  output logic        io_ifu_err,
  output logic        io_ifu_busy,
  output logic [31:0] io_mem_addr,
  output logic        io_mem_w_req,
  output logic [31:0] io_mem_w_data,
  output logic        io_mem_r_req,
  input  logic [31:0] io_mem_r_data,
  input  logic        io_mem_r_valid
);

  typedef enum logic [1:0] {IDLE, WRITE, LSU_RD, IFU_RD} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic [15:0] wait_count;
  logic        lsu_req;
  logic        lsu_pick;
  logic        grant_lsu;
  logic        grant_ifu;
  logic        timed_out;

  assign lsu_req = io_lsu_w_req | io_lsu_r_req;

`ifdef MEM_ARB_RR_EN
  // last_ifu remembers who was granted most recently; it resets to IFU so the LSU wins first.
  logic last_ifu;

  assign lsu_pick = lsu_req & (~io_ifu_r_req | last_ifu);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_ifu <= 1'b1;
    end else if (grant_lsu) begin
      last_ifu <= 1'b0;
    end else if (grant_ifu) begin
      last_ifu <= 1'b1;
    end
  end
`else
  assign lsu_pick = lsu_req;
`endif

  assign grant_lsu = (state == IDLE) & lsu_pick;
  assign grant_ifu = (state == IDLE) & io_ifu_r_req & ~lsu_pick;
  assign timed_out = (wait_count == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_reg   <= '0;
      data_reg   <= '0;
      wait_count <= '0;
    end else begin
      state <= state_next;
      if (grant_lsu) begin
        addr_reg <= io_lsu_addr;
        data_reg <= io_lsu_w_data;
      end else if (grant_ifu) begin
        addr_reg <= io_ifu_addr;
        data_reg <= '0;
      end
      // The counter is cleared while idle, so every read starts counting from zero.
      if (state == IDLE) begin
        wait_count <= '0;
      end else if (!io_mem_r_valid) begin
        wait_count <= wait_count + 16'd1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    io_mem_w_req  = 1'b0;
    io_mem_r_req  = 1'b0;
    io_lsu_done   = 1'b0;
    io_lsu_err    = 1'b0;
    io_lsu_r_data = '0;
    io_ifu_done   = 1'b0;
    io_ifu_err    = 1'b0;
    io_ifu_r_data = '0;
    case (state)
      IDLE: begin
        if (grant_lsu) begin
          state_next = io_lsu_w_req ? WRITE : LSU_RD;
        end else if (grant_ifu) begin
          state_next = IFU_RD;
        end
      end
      WRITE: begin
        io_mem_w_req = 1'b1;
        io_lsu_done  = 1'b1;
        state_next   = IDLE;
      end
      LSU_RD: begin
        io_mem_r_req = 1'b1;
        if (io_mem_r_valid) begin
          io_lsu_done   = 1'b1;
          io_lsu_r_data = io_mem_r_data;
          state_next    = IDLE;
        end else if (timed_out) begin
          io_lsu_done = 1'b1;
          io_lsu_err  = 1'b1;
          state_next  = IDLE;
        end
      end
      IFU_RD: begin
        io_mem_r_req = 1'b1;
        if (io_mem_r_valid) begin
          io_ifu_done   = 1'b1;
          io_ifu_r_data = io_mem_r_data;
          state_next    = IDLE;
        end else if (timed_out) begin
          io_ifu_done = 1'b1;
          io_ifu_err  = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign io_lsu_busy   = lsu_req & ~io_lsu_done;
  assign io_ifu_busy   = io_ifu_r_req & ~io_ifu_done;
  assign io_mem_addr   = addr_reg;
  assign io_mem_w_data = data_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  typedef struct packed {
    logic        rst;
    logic        lsu_w;
    logic        lsu_r;
    logic        ifu_r;
    logic        valid;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] ifu_addr;
    logic [31:0] rdata;
  } stim_t;

  typedef struct packed {
    logic        mem_w;
    logic        mem_r;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;
    logic        lsu_busy;
    logic        ifu_done;
    logic        ifu_err;
    logic [31:0] ifu_rdata;
    logic        ifu_busy;
  } out_t;

  typedef struct {
    stim_t in;
    out_t  exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_lsu_addr, io_lsu_w_data, io_lsu_r_data;
  logic        io_lsu_w_req, io_lsu_r_req, io_lsu_done, io_lsu_err, io_lsu_busy;
  logic [31:0] io_ifu_addr, io_ifu_r_data;
  logic        io_ifu_r_req, io_ifu_done, io_ifu_err, io_ifu_busy;
  logic [31:0] io_mem_addr, io_mem_w_data, io_mem_r_data;
  logic        io_mem_w_req, io_mem_r_req, io_mem_r_valid;

  int checks = 0;
  int passes = 0;

  // Reference model: one outstanding transaction, tracked by its age since grant.
  stim_t       cur;
  out_t        exp;
  bit          mActive = 1'b0;
  bit          mIfu = 1'b0;
  bit          mWrite = 1'b0;
  bit          mLastIfu = 1'b1;
  int          mAge = 0;
  logic [31:0] mAddr = '0;
  logic [31:0] mWdata = '0;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .io_lsu_addr(io_lsu_addr), .io_lsu_w_req(io_lsu_w_req), .io_lsu_w_data(io_lsu_w_data),
    .io_lsu_r_req(io_lsu_r_req), .io_lsu_r_data(io_lsu_r_data), .io_lsu_done(io_lsu_done),
    .io_lsu_err(io_lsu_err), .io_lsu_busy(io_lsu_busy),
    .io_ifu_addr(io_ifu_addr), .io_ifu_r_req(io_ifu_r_req), .io_ifu_r_data(io_ifu_r_data),
    .io_ifu_done(io_ifu_done), .io_ifu_err(io_ifu_err), .io_ifu_busy(io_ifu_busy),
    .io_mem_addr(io_mem_addr), .io_mem_w_req(io_mem_w_req), .io_mem_w_data(io_mem_w_data),
    .io_mem_r_req(io_mem_r_req), .io_mem_r_data(io_mem_r_data), .io_mem_r_valid(io_mem_r_valid)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mkStim(input logic rst, lw, lr, ir, vld,
                                   input logic [31:0] la, lwd, ia, rd);
    stim_t s;
    s = '{rst: rst, lsu_w: lw, lsu_r: lr, ifu_r: ir, valid: vld,
          lsu_addr: la, lsu_wdata: lwd, ifu_addr: ia, rdata: rd};
    return s;
  endfunction

  function automatic out_t mkOut(input logic mw, mr, input logic [31:0] ma, mwd,
                                 input logic ld, le, input logic [31:0] lrd, input logic lb,
                                 input logic id, ie, input logic [31:0] ird, input logic ib);
    out_t o;
    o = '{mem_w: mw, mem_r: mr, mem_addr: ma, mem_wdata: mwd, lsu_done: ld, lsu_err: le,
          lsu_rdata: lrd, lsu_busy: lb, ifu_done: id, ifu_err: ie, ifu_rdata: ird, ifu_busy: ib};
    return o;
  endfunction

  function automatic out_t sampleDut();
    out_t o;
    o = '{mem_w: io_mem_w_req, mem_r: io_mem_r_req, mem_addr: io_mem_addr,
          mem_wdata: io_mem_w_data, lsu_done: io_lsu_done, lsu_err: io_lsu_err,
          lsu_rdata: io_lsu_r_data, lsu_busy: io_lsu_busy, ifu_done: io_ifu_done,
          ifu_err: io_ifu_err, ifu_rdata: io_ifu_r_data, ifu_busy: io_ifu_busy};
    return o;
  endfunction

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %b expected %b", name, act, req);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, req);
  endtask

  task automatic compareOut(input string tag, input out_t a, input out_t e);
    check1({tag, ".mem_w_req"}, a.mem_w, e.mem_w);
    check1({tag, ".mem_r_req"}, a.mem_r, e.mem_r);
    check32({tag, ".mem_addr"}, a.mem_addr, e.mem_addr);
    check32({tag, ".mem_w_data"}, a.mem_wdata, e.mem_wdata);
    check1({tag, ".lsu_done"}, a.lsu_done, e.lsu_done);
    check1({tag, ".lsu_err"}, a.lsu_err, e.lsu_err);
    check32({tag, ".lsu_r_data"}, a.lsu_rdata, e.lsu_rdata);
    check1({tag, ".lsu_busy"}, a.lsu_busy, e.lsu_busy);
    check1({tag, ".ifu_done"}, a.ifu_done, e.ifu_done);
    check1({tag, ".ifu_err"}, a.ifu_err, e.ifu_err);
    check32({tag, ".ifu_r_data"}, a.ifu_rdata, e.ifu_rdata);
    check1({tag, ".ifu_busy"}, a.ifu_busy, e.ifu_busy);
  endtask

  task automatic driveInputs(input stim_t s);
    cur            = s;
    reset          = s.rst;
    io_lsu_w_req   = s.lsu_w;
    io_lsu_r_req   = s.lsu_r;
    io_ifu_r_req   = s.ifu_r;
    io_mem_r_valid = s.valid;
    io_lsu_addr    = s.lsu_addr;
    io_lsu_w_data  = s.lsu_wdata;
    io_ifu_addr    = s.ifu_addr;
    io_mem_r_data  = s.rdata;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clock);
    driveInputs(s);
    #2;
  endtask

  // Expected outputs for this cycle from the transaction currently in flight.
  task automatic modelEval();
    exp = '0;
    exp.mem_addr  = mAddr;
    exp.mem_wdata = mWdata;
    if (mActive) begin
      if (mWrite) begin
        exp.mem_w    = 1'b1;
        exp.lsu_done = 1'b1;
      end else begin
        exp.mem_r = 1'b1;
        if (cur.valid) begin
          if (mIfu) begin exp.ifu_done = 1'b1; exp.ifu_rdata = cur.rdata; end
          else      begin exp.lsu_done = 1'b1; exp.lsu_rdata = cur.rdata; end
        end else if (mAge == TMO) begin
          if (mIfu) begin exp.ifu_done = 1'b1; exp.ifu_err = 1'b1; end
          else      begin exp.lsu_done = 1'b1; exp.lsu_err = 1'b1; end
        end
      end
    end
    exp.lsu_busy = (cur.lsu_w | cur.lsu_r) & ~exp.lsu_done;
    exp.ifu_busy = cur.ifu_r & ~exp.ifu_done;
  endtask

  task automatic modelAdvance();
    bit lsuReq, ifuReq, lsuWins;
    lsuReq = cur.lsu_w | cur.lsu_r;
    ifuReq = cur.ifu_r;
    if (cur.rst) begin
      mActive = 1'b0; mAddr = '0; mWdata = '0; mLastIfu = 1'b1;
    end else if (mActive) begin
      if (exp.lsu_done || exp.ifu_done) mActive = 1'b0;
      else mAge++;
    end else if (lsuReq || ifuReq) begin
`ifdef MEM_ARB_RR_EN
      lsuWins = (lsuReq && ifuReq) ? mLastIfu : lsuReq;
`else
      lsuWins = lsuReq;
`endif
      mActive  = 1'b1;
      mAge     = 1;
      mIfu     = !lsuWins;
      mLastIfu = !lsuWins;
      mWrite   = lsuWins && cur.lsu_w;
      mAddr    = lsuWins ? cur.lsu_addr : cur.ifu_addr;
      mWdata   = lsuWins ? cur.lsu_wdata : 32'h0;
    end
  endtask

  task automatic checkOutput(input string tag);
    modelEval();
    compareOut(tag, sampleDut(), exp);
    modelAdvance();
  endtask

  vec_t  vecs[11];
  stim_t rs;
  bit    lPend, iPend, lCool, iCool, lsuWin;
  int    kind;

  initial begin
    driveInputs(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0));

    vecs[0]  = '{mkStim(1,0,1,1,0,0,0,0,0), mkOut(0,0,0,0, 0,0,0,1, 0,0,0,1)};
    vecs[1]  = '{mkStim(1,0,0,0,0,0,0,0,0), mkOut(0,0,0,0, 0,0,0,0, 0,0,0,0)};
    vecs[2]  = '{mkStim(0,1,0,0,0,32'h100,32'hDEADBEEF,0,0), mkOut(0,0,0,0, 0,0,0,1, 0,0,0,0)};
    vecs[3]  = '{mkStim(0,1,0,0,0,32'h100,32'hDEADBEEF,0,0),
                 mkOut(1,0,32'h100,32'hDEADBEEF, 1,0,0,0, 0,0,0,0)};
    vecs[4]  = '{mkStim(0,0,0,0,0,0,0,0,0), mkOut(0,0,32'h100,32'hDEADBEEF, 0,0,0,0, 0,0,0,0)};
    vecs[5]  = '{mkStim(0,0,0,1,0,0,0,32'h40,32'hAAAA5555),
                 mkOut(0,0,32'h100,32'hDEADBEEF, 0,0,0,0, 0,0,0,1)};
    vecs[6]  = '{mkStim(0,0,0,1,0,0,0,32'h40,32'hAAAA5555), mkOut(0,1,32'h40,0, 0,0,0,0, 0,0,0,1)};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{mkStim(0,0,0,1,1,0,0,32'h40,32'h13), mkOut(0,1,32'h40,0, 0,0,0,0, 1,0,32'h13,0)};
    vecs[10] = '{mkStim(0,0,0,0,1,0,0,0,32'h77), mkOut(0,0,32'h40,0, 0,0,0,0, 0,0,0,0)};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].in);
      compareOut($sformatf("vec%0d", i), sampleDut(), vecs[i].exp);
      checkOutput($sformatf("model_vec%0d", i));
    end

    // Both requesters contend for three rounds, every read answered in one cycle.
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("arb_reset");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(mkStim(0, 0, 1, 1, 1, 32'h500, 0, 32'h600, 32'h1000 + 32'(k)));
      if (k % 2 == 1) begin
`ifdef MEM_ARB_RR_EN
        lsuWin = (k != 3);
`else
        lsuWin = 1'b1;
`endif
        check1($sformatf("arb%0d.lsu_done", k), io_lsu_done, lsuWin);
        check1($sformatf("arb%0d.ifu_done", k), io_ifu_done, !lsuWin);
        check32($sformatf("arb%0d.mem_addr", k), io_mem_addr, lsuWin ? 32'h500 : 32'h600);
      end
      checkOutput($sformatf("arb%0d", k));
    end

    // LSU read that never gets valid: timeout four cycles after grant.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(mkStim(0, 0, 1, 0, 0, 32'h200, 0, 0, 32'hFFFF0000));
      check1($sformatf("tmo%0d.lsu_done", k), io_lsu_done, k == 4);
      check1($sformatf("tmo%0d.lsu_err", k), io_lsu_err, k == 4);
      if (k == 4) check32("tmo.lsu_r_data", io_lsu_r_data, 32'h0);
      checkOutput($sformatf("tmo%0d", k));
    end
    applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000));
    check1("tmo_after.mem_r_req", io_mem_r_req, 1'b0);
    checkOutput("tmo_after");

    // Reset in the middle of an LSU read, then a stray valid and a fresh write.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkStim(0, 0, 1, 0, 0, 32'h300, 0, 0, 0));
      checkOutput($sformatf("rstmid%0d", k));
    end
    applyStimulus(mkStim(1, 0, 1, 0, 0, 32'h300, 0, 0, 0));
    check1("rstmid.lsu_done", io_lsu_done, 1'b0);
    checkOutput("rstmid_rst");
    applyStimulus(mkStim(0, 0, 0, 0, 1, 0, 0, 0, 32'hBAD));
    check1("rstafter.mem_r_req", io_mem_r_req, 1'b0);
    check1("rstafter.lsu_done", io_lsu_done, 1'b0);
    check1("rstafter.ifu_done", io_ifu_done, 1'b0);
    checkOutput("rstafter");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(mkStim(0, 1, 0, 0, 0, 32'h400, 32'h12345678, 0, 0));
      if (k == 1) begin
        check1("rstwr.mem_w_req", io_mem_w_req, 1'b1);
        check1("rstwr.lsu_done", io_lsu_done, 1'b1);
        check32("rstwr.mem_addr", io_mem_addr, 32'h400);
      end
      checkOutput($sformatf("rstwr%0d", k));
    end

    // Randomized traffic obeying the requester protocol, checked against the model.
    rs = '0;
    lPend = 0; iPend = 0; lCool = 0; iCool = 0;
    for (int n = 0; n < 2000; n++) begin
      rs.rst = ($urandom_range(0, 199) == 0);
      if (!lPend && !lCool && $urandom_range(0, 2) == 0) begin
        lPend = 1;
        kind = $urandom_range(0, 2);
        rs.lsu_w = (kind != 1);
        rs.lsu_r = (kind != 0);
        rs.lsu_addr = $urandom;
        rs.lsu_wdata = $urandom;
      end
      if (!iPend && !iCool && $urandom_range(0, 2) == 0) begin
        iPend = 1;
        rs.ifu_addr = $urandom;
      end
      if (!lPend) begin rs.lsu_w = 0; rs.lsu_r = 0; end
      rs.ifu_r = iPend;
      rs.valid = ($urandom_range(0, 2) == 0);
      rs.rdata = $urandom;
      applyStimulus(rs);
      checkOutput("rand");
      lCool = exp.lsu_done;
      iCool = exp.ifu_done;
      if (exp.lsu_done || rs.rst) lPend = 0;
      if (exp.ifu_done || rs.rst) iPend = 0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
